// File: rtl/csa_resolver.sv
// csa_resolver
//   Resolves a carry-save pair into a single binary sum. A chunked
//   carry-propagate adder handles CHUNK bits per cycle and keeps the carry
//   between chunks in a register. One operand pair is in flight at a time.
//   When the output is never stalled, a result is produced every NCHUNK+1 cycles.
//
// Ports
//   clock      in   rising-edge clock
//   reset      in   asynchronous active-low reset
//   in_valid   in   carry-save pair on in_0/in_1 is valid
//   in_ready   out  a pair is accepted this cycle
//   in_0       in   [WIDTH-1:0] sum vector
//   in_1       in   [WIDTH-1:0] carry vector (weight-aligned)
//   out_valid  out  out_sum holds a completed result
//   out_ready  in   consumer takes the result this cycle
//   out_sum    out  [WIDTH:0] in_0 + in_1, exact
module csa_resolver #(
    parameter int WIDTH = 21,
    parameter int CHUNK = 7
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_0,
    input  logic [WIDTH-1:0] in_1,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   out_sum
);

    localparam int NCHUNK = (WIDTH + CHUNK - 1) / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    // Number of real operand bits in the last chunk (1..CHUNK).
    localparam int TOPB   = WIDTH - (NCHUNK - 1) * CHUNK;

    typedef enum logic [1:0] {S_IDLE, S_ADD, S_DONE} state_t;

    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_op0, r_op1;
    logic [WIDTH:0]   r_sum;
    logic             r_carry;
    logic [IDXW-1:0]  r_idx;

    logic [CHUNK-1:0] w_a, w_b, w_s;
    logic             w_c, w_top, w_last, w_accept;

    // Select the current chunk. Bits beyond WIDTH-1 stay zero, which pads the last chunk.
    always_comb begin
        w_a = '0;
        w_b = '0;
        for (int unsigned b = 0; b < WIDTH; b++) begin
            if (r_idx == IDXW'(b / CHUNK)) begin
                w_a[b % CHUNK] = r_op0[b];
                w_b[b % CHUNK] = r_op1[b];
            end
        end
    end

    assign {w_c, w_s} = {1'b0, w_a} + {1'b0, w_b} + {{CHUNK{1'b0}}, r_carry};
    assign w_last     = (r_idx == IDXW'(NCHUNK - 1));

    // When the last chunk is padded, the carry into bit WIDTH lands inside
    // the chunk sum instead of at its carry-out.
    if (TOPB < CHUNK) begin : g_pad
        assign w_top = w_s[TOPB];
    end else begin : g_nopad
        assign w_top = w_c;
    end

    always_comb begin
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                in_ready = reset;
                if (in_valid) w_state_nxt = S_ADD;
            end
            S_ADD: begin
                if (w_last) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                out_valid = 1'b1;
                in_ready  = reset & out_ready;
                if (out_ready) w_state_nxt = in_valid ? S_ADD : S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_accept = in_valid & in_ready;
    assign out_sum  = r_sum;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_op0   <= '0;
            r_op1   <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_idx   <= '0;
        end else if (w_accept) begin
            r_op0   <= in_0;
            r_op1   <= in_1;
            r_carry <= 1'b0;
            r_idx   <= '0;
        end else if (r_state == S_ADD) begin
            for (int unsigned b = 0; b < WIDTH; b++) begin
                if (r_idx == IDXW'(b / CHUNK)) r_sum[b] <= w_s[b % CHUNK];
            end
            if (w_last) r_sum[WIDTH] <= w_top;
            r_carry <= w_c;
            r_idx   <= r_idx + IDXW'(1);
        end
    end

endmodule
